bcd_serial_add_ctrl: RTL
========================

# bcd_serial_add_ctrl

Sequencer that performs multi-digit packed-BCD addition by time-sharing one existing single-digit `bcd_adder` instance. It processes one digit per clock, least-significant first, and carries the digit carry in a register between cycles. It sits between a requester (start/ready/done handshake) and the digit adder, and holds the registered multi-digit result until the next operation.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand. Minimum 1.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request. Sampled only while `ready`=1.
- `a` input 4*DIGITS: operand A, packed BCD, digit 0 in [3:0].
- `b` input 4*DIGITS: operand B, packed BCD.
- `carry_in` input 1: carry into digit 0.
- `ready` output 1: controller idle, `start` will be accepted.
- `done` output 1: one-cycle pulse; `sum`, `carry` and `err` are valid from this cycle on.
- `sum` output 4*DIGITS: registered BCD result.
- `carry` output 1: carry out of the top digit.
- `err` output 1: invalid input digit detected (only with `BCD_CHECK_EN`).

## Operation
- FSM states are IDLE, ADD and DONE.
- IDLE:
  - `ready`=1.
  - On `start`=1, latch `a`, `b` and `carry_in` into internal registers, clear the digit index, and go to ADD.
- ADD:
  - Each cycle, drive the digit adder with latched digit[idx] of A and B and the carry register.
  - Write the adder's sum digit into `sum` digit[idx] and its carry into the carry register.
  - Increment idx. After digit DIGITS-1, go to DONE.
- DONE:
  - `done`=1 and `carry` = final carry register.
  - Next cycle, go to IDLE.
- Digit arithmetic: the digit adder returns (a+b+cin) mod 10 with carry = (a+b+cin ≥ 10). The full result equals decimal A+B+carry_in modulo 10^DIGITS, with the overflow reported on `carry`.
- `sum`, `carry` and `err` hold their values from DONE until the next accepted `start`. They are not cleared at the start of the new operation; they update digit by digit.
- While in ADD or DONE, `start` is ignored and input changes have no effect, because operands are latched.
- Index width is clog2(DIGITS), minimum 1. The index never wraps past DIGITS-1.

## Timing
- Reset values: `ready`=1, `done`=0, `sum`=0, `carry`=0, `err`=0, state IDLE, index 0, carry register 0.
- `rst` takes priority in every state. An operation aborted by reset produces no `done`, and `ready`=1 on the cycle after reset is released.
- If `start` is accepted on cycle 0:
  - ADD occupies cycles 1 to DIGITS.
  - `done`=1 on cycle DIGITS+1.
  - `ready`=1 again on cycle DIGITS+2.
- Throughput is one operation per DIGITS+2 cycles.
- `start` held high continuously restarts immediately on each return to IDLE.
- `ready`=0 during ADD and DONE.
- DIGITS=1 gives one ADD cycle and `done` on cycle 2.

## Configuration
- `BCD_CHECK_EN` defined:
  - In ADD, any latched A or B digit greater than 9 sets a sticky error flag.
  - In DONE, `err` = flag, `sum` = 0 and `carry` = 0.
  - The flag clears on accepting `start`.
- `BCD_CHECK_EN` undefined:
  - `err` is tied to 0 and no checking logic is built.
  - Invalid digits pass to the digit adder unchecked, and the result is unspecified.

## Structure
- Shared package `bcd_pkg`:
  - state enum (IDLE, ADD, DONE)
  - `BCD_DIGIT_W`=4
  - `BCD_MAX_DIGIT`=9
- One sub-module: the existing `bcd_adder`, instantiated once as the digit datapath. The controller contains no digit arithmetic of its own.

## Test plan
- DIGITS=4, a=1234, b=5678, carry_in=0, start on cycle 0 → `done` on cycle 5, sum=6912, carry=0, `ready` on cycle 6.
- a=9999, b=0001, carry_in=0 → sum=0000, carry=1; carry ripples through all four ADD cycles.
- a=9999, b=9999, carry_in=1 → sum=9999, carry=1. Then a=0000, b=0000, carry_in=1 back-to-back → sum=0001, carry=0.
- `start` pulsed again on cycles 2 and 5 of an operation → ignored: exactly one `done`, and the result matches the first operands.
- `rst` asserted on cycle 3 (mid-ADD) → no `done`; next cycle `ready`=1, sum=0, carry=0. A new start then completes correctly.
- With `BCD_CHECK_EN`: a=0x12A4, b=0x0001 → `done` on cycle 5 with err=1, sum=0. A following valid add gives err=0. Without the macro, `err` stays 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD adder slice
package bcd_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/bcd_adder.sv
// rtl/bcd_adder.sv - single-digit BCD adder: (a+b+cin) mod 10 with decimal carry
import bcd_pkg::*;

module bcd_adder (
  input  logic [BCD_DIGIT_W-1:0] a_i,
  input  logic [BCD_DIGIT_W-1:0] b_i,
  input  logic                   cin_i,
  output logic [BCD_DIGIT_W-1:0] sum_o,
  output logic                   cout_o
);

  // Five bits cover the largest binary sum of two nibbles plus carry.
  logic [BCD_DIGIT_W:0] raw;
  logic [BCD_DIGIT_W:0] adj;

  assign raw    = {1'b0, a_i} + {1'b0, b_i} + {{BCD_DIGIT_W{1'b0}}, cin_i};
  assign cout_o = (raw >= (BCD_DIGIT_W+1)'(10));
  assign adj    = raw - (BCD_DIGIT_W+1)'(10);
  assign sum_o  = cout_o ? adj[BCD_DIGIT_W-1:0] : raw[BCD_DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder sequencer (optional BCD_CHECK_EN digit check)
import bcd_pkg::*;

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          carry_in,
  output logic                          ready,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          carry,
  output logic                          err
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  bcd_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             cy_q, cy_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;

  logic [BCD_DIGIT_W-1:0] dig_a;
  logic [BCD_DIGIT_W-1:0] dig_b;
  logic [BCD_DIGIT_W-1:0] add_sum;
  logic                   add_cout;

  assign dig_a = a_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign dig_b = b_q[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W];

  bcd_adder u_digit (
    .a_i    (dig_a),
    .b_i    (dig_b),
    .cin_i  (cy_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

`ifdef BCD_CHECK_EN
  localparam logic [BCD_DIGIT_W-1:0] MAX_DIG = BCD_DIGIT_W'(BCD_MAX_DIGIT);

  logic flag_q, flag_d;
  logic err_q, err_d;
  logic dig_bad;

  assign dig_bad = (dig_a > MAX_DIG) || (dig_b > MAX_DIG);
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ready   = 1'b0;
    done    = 1'b0;
`ifdef BCD_CHECK_EN
    flag_d  = flag_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = b;
          cy_d    = carry_in;
          idx_d   = '0;
          state_d = ADD;
`ifdef BCD_CHECK_EN
          flag_d  = 1'b0;
`endif
        end
      end
      ADD: begin
        sum_d[idx_q*BCD_DIGIT_W +: BCD_DIGIT_W] = add_sum;
        cy_d = add_cout;
`ifdef BCD_CHECK_EN
        flag_d = flag_q | dig_bad;
`endif
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          carry_d = add_cout;
`ifdef BCD_CHECK_EN
          // An invalid digit anywhere poisons the whole result.
          err_d = flag_d;
          if (flag_d) begin
            sum_d   = '0;
            carry_d = 1'b0;
          end
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef BCD_CHECK_EN
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef BCD_CHECK_EN
      flag_q  <= flag_d;
      err_q   <= err_d;
`endif
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule
